ag32gbd_sram_arbiter: RTL and testbench
=======================================

AG32GBD_SRAM_ARBITER -- requirements
Module: ag32gbd_sram_arbiter

Interface
REQ-001 Parameters SHALL be:
- T_SETUP, default 2, address/nCS setup cycles before strobe (range 1-15).
- T_PULSE, default 3, nWE/nOE low cycles (range 1-15).
- T_HOLD, default 1, address/data hold cycles after strobe (range 1-15).
- STARVE_LIMIT, default 4, consecutive port-0 grants before port 1 is forced (range 1-15).

REQ-002 Ports SHALL be:
- sys_clock  in  1  single clock; all logic on its rising edge.
- sys_reset  in  1  synchronous, active-high reset.
- p0_req / p1_req  in  1  transaction request; held high until the matching ack.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  17  SRAM byte address.
- p0_wdata / p1_wdata  in  8  write data.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_rdata / p1_rdata  out  8  read data; valid while ack is high, then held.
- sram_addr  out  17  SRAM address pins.
- sram_dq_out  out  8  SRAM data out.
- sram_dq_oe  out  1  data-bus drive enable.
- sram_dq_in  in  8  SRAM data in.
- sram_nCS / sram_nWE / sram_nOE  out  1  SRAM strobes, active low.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  port owning the current or last transaction.

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP, PULSE, HOLD and ACK, with each of SETUP, PULSE and HOLD lasting exactly its parameter in cycles.

REQ-004 In IDLE with any req high, the block SHALL pick a port, latch its we, addr and wdata, set grant_id, drive sram_addr, pull sram_nCS low and enter SETUP on the next edge.

REQ-005 Arbitration SHALL be fixed priority, with port 0 winning when both requests are high in the same IDLE cycle.

REQ-006 For a write, sram_dq_out SHALL carry the latched data and sram_dq_oe SHALL be 1 from SETUP through HOLD.

REQ-007 For a write, sram_nWE SHALL be 0 only during PULSE, and sram_nOE SHALL stay 1.

REQ-008 For a read, sram_dq_oe SHALL be 0 and sram_nOE SHALL be 0 only during PULSE.

REQ-009 For a read, sram_dq_in SHALL be registered on the last PULSE cycle.

REQ-010 sram_addr and sram_nCS=0 SHALL remain stable from SETUP through HOLD.

REQ-011 sram_nCS SHALL return to 1 in ACK.

REQ-012 In ACK, the block SHALL pulse the granted port's ack for exactly one cycle, present read data on that port's rdata, and return to IDLE.

REQ-013 Requests SHALL be sampled in IDLE only, and req changes in other states SHALL be ignored.

REQ-014 The IDLE cycle after ACK SHALL evaluate requests afresh, with no re-grant of a request dropped in response to ack.

REQ-015 Latency SHALL be fixed: with the sampling IDLE cycle counted as cycle 0, ack SHALL occur at cycle 1+T_SETUP+T_PULSE+T_HOLD (cycle 7 with defaults).

REQ-016 Back-to-back transactions SHALL have a minimum spacing of 2+T_SETUP+T_PULSE+T_HOLD cycles between grants.

REQ-017 The strobes sram_nWE and sram_nOE SHALL never be low simultaneously, and sram_dq_oe SHALL never be 1 while sram_nOE is 0.

REQ-018 The inactive port's ack SHALL remain 0, and its rdata SHALL hold its previous value.

REQ-019 Address and data SHALL pass through unmodified with no wrap or increment logic, so that 17'h1FFFF is a legal address.

Reset
REQ-020 On sys_reset=1, the block SHALL at the next edge enter IDLE and clear the following:
- sram_nCS, sram_nWE and sram_nOE to 1.
- sram_dq_oe, sram_dq_out and sram_addr to 0.
- p0_ack, p1_ack, p0_rdata and p1_rdata to 0.
- busy, grant_id and the starvation counter to 0.

REQ-021 A reset during any state SHALL abort the transaction with no ack issued, and the requester SHALL re-request.

REQ-022 In-flight timing counters SHALL be cleared by reset.

Configuration
REQ-023 With macro AG32GBD_ARB_STARVE_GUARD_EN defined, a 4-bit counter SHALL count consecutive port-0 grants made while p1_req is high.

REQ-024 Under AG32GBD_ARB_STARVE_GUARD_EN, when the counter equals STARVE_LIMIT and both requests are high, port 1 SHALL be granted, and the counter SHALL clear on any port-1 grant or on any IDLE with p1_req low.

REQ-025 Without AG32GBD_ARB_STARVE_GUARD_EN, the counter logic SHALL be absent and arbitration SHALL be pure REQ-005 priority.

Verification
REQ-026 Single write: p1 write to addr 17'h00123 with data 8'hA5, defaults → nCS low cycles 1-6, nWE low cycles 3-5, dq_oe high cycles 1-6, p1_ack high at cycle 7.

REQ-027 Single read: p0 read at 17'h1FFFF with sram_dq_in=8'h3C during PULSE → nOE low cycles 3-5, dq_oe 0 throughout, p0_rdata=8'h3C with p0_ack at cycle 7.

REQ-028 Simultaneous requests: p0 and p1 raised in the same cycle → p0 served first, p1 granted in the IDLE cycle right after p0's ACK, with p1_ack at cycle 8 after p0_ack.

REQ-029 Starvation guard: with AG32GBD_ARB_STARVE_GUARD_EN and STARVE_LIMIT=4, p0 re-requesting continuously and p1 held high → grants follow p0,p0,p0,p0,p1,p0…; without the macro, p1 is never granted.

REQ-030 Mid-operation reset: sys_reset asserted during PULSE of a write → strobes high and dq_oe 0 the next cycle, no ack, then the held req is re-granted and completes normally after reset is released.

REQ-031 Protocol invariants, asserted throughout all scenarios: nWE and nOE never both low; dq_oe never high while nOE is low; at most one ack high in any cycle.

Source files
------------

// File: rtl/ag32gbd_sram_arbiter.sv
`timescale 1ns/1ps
// ag32gbd_sram_arbiter
// Two-port arbiter in front of an asynchronous SRAM (17-bit address, 8-bit data).
// Each granted transaction runs SETUP / PULSE / HOLD for a fixed number of
// cycles and then pulses the owning port's ack for one cycle.
//
// Ports:
//   sys_clock, sys_reset       clock, synchronous active-high reset
//   pN_req/we/addr/wdata       port N request (held until ack)
//   pN_ack, pN_rdata           port N completion pulse and read data (held)
//   sram_addr, sram_dq_out     SRAM address and write data
//   sram_dq_oe, sram_dq_in     data-bus drive enable and read data in
//   sram_nCS/nWE/nOE           SRAM strobes, active low
//   busy, grant_id             not idle; port owning current/last transaction
//
// Optional: define AG32GBD_ARB_STARVE_GUARD_EN to force a port-1 grant after
// STARVE_LIMIT consecutive port-0 grants made while port 1 was waiting.
//
// state | meaning
// IDLE  | sample requests, latch winner's command
// SETUP | address and nCS asserted, strobes high
// PULSE | nWE (write) or nOE (read) low; read data captured on last cycle
// HOLD  | strobes high, address/data still driven
// ACK   | nCS released, one-cycle ack to the granted port
module ag32gbd_sram_arbiter #(
  parameter int unsigned T_SETUP      = 2,
  parameter int unsigned T_PULSE      = 3,
  parameter int unsigned T_HOLD       = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [16:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  output logic        p0_ack,
  output logic [7:0]  p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [16:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p1_ack,
  output logic [7:0]  p1_rdata,
  output logic [16:0] sram_addr,
  output logic [7:0]  sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [7:0]  sram_dq_in,
  output logic        sram_nCS,
  output logic        sram_nWE,
  output logic        sram_nOE,
  output logic        busy,
  output logic        grant_id
);

  if (T_SETUP < 1 || T_SETUP > 15 || T_PULSE < 1 || T_PULSE > 15 ||
      T_HOLD < 1 || T_HOLD > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
    $error("ag32gbd_sram_arbiter: timing/starve parameter out of range 1-15");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_ACK} state_t;

  // Timers load (N-1) on phase entry and count down to a terminal count of 0.
  localparam logic [3:0] SETUP_LD = 4'(T_SETUP - 1);
  localparam logic [3:0] PULSE_LD = 4'(T_PULSE - 1);
  localparam logic [3:0] HOLD_LD  = 4'(T_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  tmr_q, tmr_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [7:0]  p0_rdata_q, p0_rdata_d;
  logic [7:0]  p1_rdata_q, p1_rdata_d;
  logic        force_p1;
  logic        pick_p1;
  logic        grant_now;

  assign grant_now = (state_q == S_IDLE) && (p0_req || p1_req);
  assign pick_p1   = p1_req && (!p0_req || force_p1);

`ifdef AG32GBD_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign force_p1 = p0_req && p1_req && (starve_q == 4'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (!p1_req || (grant_now && pick_p1)) begin
        starve_d = 4'd0;
      end else if (grant_now && starve_q != 4'hF) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (sys_reset) starve_q <= 4'd0;
    else           starve_q <= starve_d;
  end
`else
  assign force_p1 = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    grant_d    = grant_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_now) begin
          grant_d = pick_p1;
          we_d    = pick_p1 ? p1_we    : p0_we;
          addr_d  = pick_p1 ? p1_addr  : p0_addr;
          wdata_d = pick_p1 ? p1_wdata : p0_wdata;
          tmr_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_q == 4'd0) begin
          tmr_d   = PULSE_LD;
          state_d = S_PULSE;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end
      S_PULSE: begin
        if (tmr_q == 4'd0) begin
          if (!we_q) rbuf_d = sram_dq_in;
          tmr_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (tmr_q == 4'd0) begin
          // Port rdata only changes as ack rises, so it never moves early.
          if (!we_q) begin
            if (grant_q) p1_rdata_d = rbuf_q;
            else         p0_rdata_d = rbuf_q;
          end
          state_d = S_ACK;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      state_q    <= S_IDLE;
      tmr_q      <= 4'd0;
      grant_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 17'd0;
      wdata_q    <= 8'd0;
      rbuf_q     <= 8'd0;
      p0_rdata_q <= 8'd0;
      p1_rdata_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  logic in_xfer;
  assign in_xfer = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD);

  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign sram_dq_oe  = in_xfer && we_q;
  assign sram_nCS    = !in_xfer;
  assign sram_nWE    = !((state_q == S_PULSE) && we_q);
  assign sram_nOE    = !((state_q == S_PULSE) && !we_q);
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_q;
  assign p0_ack      = (state_q == S_ACK) && !grant_q;
  assign p1_ack      = (state_q == S_ACK) && grant_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;

endmodule

// File: tb/tb_ag32gbd_sram_arbiter.sv
`timescale 1ns/1ps
module tb_ag32gbd_sram_arbiter;

  localparam int TS  = 2;
  localparam int TP  = 3;
  localparam int TH  = 1;
  localparam int LAT = 1 + TS + TP + TH;

  logic        sys_clock = 1'b0;
  logic        sys_reset = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [16:0] p0_addr = '0;
  logic [7:0]  p0_wdata = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [16:0] p1_addr = '0;
  logic [7:0]  p1_wdata = '0;
  logic        p0_ack, p1_ack;
  logic [7:0]  p0_rdata, p1_rdata;
  logic [16:0] sram_addr;
  logic [7:0]  sram_dq_out;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_in;
  logic        sram_nCS, sram_nWE, sram_nOE;
  logic        busy, grant_id;

  ag32gbd_sram_arbiter dut (
    .sys_clock(sys_clock), .sys_reset(sys_reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_nCS(sram_nCS), .sram_nWE(sram_nWE),
    .sram_nOE(sram_nOE), .busy(busy), .grant_id(grant_id)
  );

  always #5 sys_clock = ~sys_clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int noe_cnt = 0;
  logic [7:0] prev0 = '0, prev1 = '0;
  logic       rst_prev = 1'b1;

  always @(posedge sys_clock) cyc++;

  // SRAM model: returns valid data only on the last nOE-low cycle.
  function automatic logic [7:0] mem_of(input logic [16:0] a);
    return a[7:0] ^ a[16:9] ^ 8'h3C;
  endfunction
  assign sram_dq_in = (!sram_nOE && noe_cnt == TP) ? mem_of(sram_addr) : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  always @(negedge sys_clock) begin
    exp_t e;
    noe_cnt = sram_nOE ? 0 : noe_cnt + 1;
    if (!sys_reset) begin
      check("inv_nwe_noe", {31'd0, !sram_nWE && !sram_nOE}, 0);
      check("inv_oe_noe", {31'd0, sram_dq_oe && !sram_nOE}, 0);
      check("inv_two_acks", {31'd0, p0_ack && p1_ack}, 0);
    end
    if (p0_ack || p1_ack) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", {30'd0, p1_ack, p0_ack}, 0);
      end else begin
        e = sb.pop_front();
        check("ack_port", {31'd0, p1_ack}, {31'd0, e.port});
        check("ack_cycle", cyc, e.cyc);
        if (!e.we) check("ack_rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
      end
    end
    if (!(sys_reset || rst_prev)) begin
      if (!p0_ack) check("p0_rdata_hold", p0_rdata, prev0);
      if (!p1_ack) check("p1_rdata_hold", p1_rdata, prev1);
    end
    prev0 = p0_rdata;
    prev1 = p1_rdata;
    rst_prev = sys_reset;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drive(input bit port, input bit we, input logic [16:0] a, input logic [7:0] d);
    if (port) begin p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1'b1; end
    else      begin p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1'b1; end
  endtask

  // Advance n cycles; requesters drop req the cycle after seeing their ack.
  task automatic run(input int n, input bit keep0);
    bit a0, a1;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clock);
      a0 = p0_ack;
      a1 = p1_ack;
      @(posedge sys_clock);
      #1;
      if (a0 && !keep0) p0_req = 1'b0;
      if (a1)           p1_req = 1'b0;
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t vecs[6];

  task automatic do_single(input vec_t v);
    int k;
    bit act, pulse, a0, a1;
    k = cyc;
    drive(v.port, v.we, v.addr, v.wdata);
    sb.push_back('{v.port, v.we, v.exp_rdata, k + LAT});
    for (int c = 0; c <= LAT + 1; c++) begin
      @(negedge sys_clock);
      act   = (c >= 1) && (c <= TS + TP + TH);
      pulse = (c >= TS + 1) && (c <= TS + TP);
      check($sformatf("nCS@%0d", c), {31'd0, sram_nCS}, {31'd0, !act});
      check($sformatf("nWE@%0d", c), {31'd0, sram_nWE}, {31'd0, !(v.we && pulse)});
      check($sformatf("nOE@%0d", c), {31'd0, sram_nOE}, {31'd0, !(!v.we && pulse)});
      check($sformatf("dq_oe@%0d", c), {31'd0, sram_dq_oe}, {31'd0, v.we && act});
      check($sformatf("busy@%0d", c), {31'd0, busy}, {31'd0, (c >= 1) && (c <= LAT)});
      if (act) check($sformatf("addr@%0d", c), {15'd0, sram_addr}, {15'd0, v.addr});
      if (act && v.we) check($sformatf("dq_out@%0d", c), {24'd0, sram_dq_out}, {24'd0, v.wdata});
      if (c >= 1) check($sformatf("grant_id@%0d", c), {31'd0, grant_id}, {31'd0, v.port});
      a0 = p0_ack;
      a1 = p1_ack;
      @(posedge sys_clock);
      #1;
      if (a0) p0_req = 1'b0;
      if (a1) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  initial begin
    int k;
    bit exp_port[6];

    vecs[0] = '{1'b1, 1'b1, 17'h00123, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 17'h1FFFF, 8'h00, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 17'h1FFFF, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 17'h15555, 8'h00, 8'hC3};
    vecs[4] = '{1'b0, 1'b1, 17'h0AAAA, 8'h5A, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 17'h00ABC, 8'h00, 8'h85};

    // Reset state
    repeat (3) @(posedge sys_clock);
    #1;
    sys_reset = 1'b0;
    check("rst_nCS", {31'd0, sram_nCS}, 1);
    check("rst_nWE", {31'd0, sram_nWE}, 1);
    check("rst_nOE", {31'd0, sram_nOE}, 1);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 0);
    check("rst_dq_out", {24'd0, sram_dq_out}, 0);
    check("rst_addr", {15'd0, sram_addr}, 0);
    check("rst_acks", {30'd0, p1_ack, p0_ack}, 0);
    check("rst_rdata", {16'd0, p1_rdata, p0_rdata}, 0);
    check("rst_busy_grant", {30'd0, busy, grant_id}, 0);
    run(2, 1'b0);

    // Single transactions from the table
    foreach (vecs[i]) begin
      do_single(vecs[i]);
      run(1, 1'b0);
    end

    // Request toggled mid-transaction must be ignored
    k = cyc;
    drive(1'b0, 1'b0, 17'h1FFFF, 8'h00);
    sb.push_back('{1'b0, 1'b0, 8'h3C, k + LAT});
    run(2, 1'b0);
    drive(1'b1, 1'b1, 17'h00001, 8'h77);
    run(3, 1'b0);
    p1_req = 1'b0;
    run(6, 1'b0);
    check("ignored_req_grant", {31'd0, grant_id}, 0);

    // Simultaneous requests: p0 first, p1 right after p0's ack
    k = cyc;
    drive(1'b0, 1'b1, 17'h00042, 8'h11);
    drive(1'b1, 1'b0, 17'h15555, 8'h00);
    sb.push_back('{1'b0, 1'b1, 8'h00, k + LAT});
    sb.push_back('{1'b1, 1'b0, 8'hC3, k + 2 * LAT + 1});
    run(2 * LAT + 4, 1'b0);

    // Starvation: p0 re-requests continuously, p1 held high
`ifdef AG32GBD_ARB_STARVE_GUARD_EN
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    k = cyc;
    drive(1'b0, 1'b0, 17'h00ABC, 8'h00);
    drive(1'b1, 1'b1, 17'h00123, 8'hA5);
    for (int i = 0; i < 6; i++)
      sb.push_back('{exp_port[i], exp_port[i], 8'h85, k + LAT + i * (LAT + 1)});
    run(6 * (LAT + 1), 1'b1);
    p0_req = 1'b0;
    p1_req = 1'b0;
    run(10, 1'b0);

    // Reset during PULSE of a write, then re-grant of the held request
    k = cyc;
    drive(1'b0, 1'b1, 17'h0F0F0, 8'h3A);
    run(1 + TS, 1'b0);
    sys_reset = 1'b1;
    @(negedge sys_clock);
    check("mid_nWE_low", {31'd0, sram_nWE}, 0);
    @(posedge sys_clock);
    #1;
    sys_reset = 1'b0;
    check("abort_strobes", {29'd0, sram_nCS, sram_nWE, sram_nOE}, 3'b111);
    check("abort_dq_oe", {31'd0, sram_dq_oe}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_addr", {15'd0, sram_addr}, 0);
    check("abort_rdata", {24'd0, p0_rdata}, 0);
    sb.push_back('{1'b0, 1'b1, 8'h00, cyc + LAT});
    run(LAT + 4, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
